// File: rtl/watch_pkg.sv
// Shared types, digit limits and hour-format helpers for the watch timekeeper.
// Hours travel between helpers as 7-bit binary so 12h/24h arithmetic stays simple.
package watch_pkg;

  typedef enum logic [0:0] {ST_STOPPED, ST_RUNNING} state_e;

  localparam logic [3:0] SEC1_MAX  = 4'd5;
  localparam logic [3:0] MIN1_MAX  = 4'd5;
  localparam logic [6:0] HR_MAX_24 = 7'd23;

  function automatic logic [6:0] bcd_to_bin(input logic [3:0] d1, input logic [3:0] d0);
    return 7'(d1) * 7'd10 + 7'(d0);
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [6:0] b);
    logic [3:0] tens;
    logic [6:0] ones;
    if (b >= 7'd20) begin
      tens = 4'd2;
      ones = b - 7'd20;
    end else if (b >= 7'd10) begin
      tens = 4'd1;
      ones = b - 7'd10;
    end else begin
      tens = 4'd0;
      ones = b;
    end
    return {tens, ones[3:0]};
  endfunction

  // 12h hour (1..12) plus PM flag to internal 0..23
  function automatic logic [6:0] hr_12_to_24(input logic [6:0] h, input logic pm);
    if (h == 7'd12) return pm ? 7'd12 : 7'd0;
    return pm ? h + 7'd12 : h;
  endfunction

  function automatic logic [6:0] hr_24_to_12(input logic [6:0] h);
    if (h == 7'd0) return 7'd12;
    if (h <= 7'd12) return h;
    return h - 7'd12;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Single BCD digit counting 0..MOD-1 with synchronous load and ripple-free carry-out.
module bcd_mod_counter #(
  parameter int unsigned MOD = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] q_o,
  output logic       carry_o
);

  localparam logic [3:0] Last = 4'(MOD - 1);

  logic [3:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = (q_q == Last) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= 4'd0;
    else       q_q <= q_d;
  end

  assign q_o     = q_q;
  assign carry_o = en_i && (q_q == Last);

endmodule

// File: rtl/watch_core.sv
// Single-clock BCD timekeeper: prescaled one-second tick, validated load, 12h/24h display.
// Time is held internally as 24h BCD; display hours are formatted combinationally.
module watch_core
  import watch_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 1000,
  parameter int unsigned PRE_W       = $clog2(CLK_PER_SEC + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       set_time,
  input  logic       mode24,
  input  logic [3:0] in_hr1,
  input  logic [3:0] in_hr0,
  input  logic [3:0] in_min1,
  input  logic [3:0] in_min0,
  input  logic [3:0] in_sec1,
  input  logic [3:0] in_sec0,
  input  logic       in_pm,
  output logic [3:0] hr1,
  output logic [3:0] hr0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic       pm,
  output logic       daypass,
  output logic       sec_tick,
  output logic       running,
  output logic       load_err
);

  localparam logic [PRE_W-1:0] PreLast = PRE_W'(CLK_PER_SEC - 1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       hr1_q, hr0_q;
  logic [7:0]       hr_d;
  logic             sec_tick_q, daypass_q, load_err_q;

  logic       tick, load_ok, digits_ok, hr_ok, hr_last;
  logic       c_s0, c_s1, c_m0, c_m1;
  logic [6:0] in_hr_bin, hr_bin;
  logic [7:0] load_hr, disp_hr;

  assign running = (state_q == ST_RUNNING);
  // A load, valid or not, owns the cycle and suppresses the tick.
  assign tick    = running && (pre_q == PreLast) && !set_time;

  assign in_hr_bin = bcd_to_bin(in_hr1, in_hr0);
  assign digits_ok = (in_hr1 <= 4'd9) && (in_hr0 <= 4'd9) && (in_min0 <= 4'd9)
                  && (in_sec0 <= 4'd9) && (in_min1 <= MIN1_MAX) && (in_sec1 <= SEC1_MAX);
  assign hr_ok     = mode24 ? (in_hr_bin <= HR_MAX_24)
                            : (in_hr_bin >= 7'd1 && in_hr_bin <= 7'd12);
  assign load_ok   = set_time && digits_ok && hr_ok;
  assign load_hr   = mode24 ? {in_hr1, in_hr0} : bin_to_bcd(hr_12_to_24(in_hr_bin, in_pm));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOPPED: if (start_resume && !stop) state_d = ST_RUNNING;
      ST_RUNNING: if (stop) state_d = ST_STOPPED;
    endcase
  end

  always_comb begin
    pre_d = pre_q;
    if (set_time) begin
      if (load_ok) pre_d = '0;
    end else if (running) begin
      pre_d = (pre_q == PreLast) ? '0 : pre_q + PRE_W'(1);
    end
  end

  bcd_mod_counter #(.MOD(10)) u_sec0 (
    .clk_i(clk), .rst_i(reset), .en_i(tick), .load_i(load_ok),
    .load_val_i(in_sec0), .q_o(sec0), .carry_o(c_s0)
  );
  bcd_mod_counter #(.MOD(6)) u_sec1 (
    .clk_i(clk), .rst_i(reset), .en_i(c_s0), .load_i(load_ok),
    .load_val_i(in_sec1), .q_o(sec1), .carry_o(c_s1)
  );
  bcd_mod_counter #(.MOD(10)) u_min0 (
    .clk_i(clk), .rst_i(reset), .en_i(c_s1), .load_i(load_ok),
    .load_val_i(in_min0), .q_o(min0), .carry_o(c_m0)
  );
  bcd_mod_counter #(.MOD(6)) u_min1 (
    .clk_i(clk), .rst_i(reset), .en_i(c_m0), .load_i(load_ok),
    .load_val_i(in_min1), .q_o(min1), .carry_o(c_m1)
  );

  assign hr_bin  = bcd_to_bin(hr1_q, hr0_q);
  assign hr_last = (hr_bin == HR_MAX_24);

  always_comb begin
    hr_d = {hr1_q, hr0_q};
    if (load_ok) begin
      hr_d = load_hr;
    end else if (c_m1) begin
      if (hr_last)              hr_d = 8'h00;
      else if (hr0_q == 4'd9)   hr_d = {hr1_q + 4'd1, 4'd0};
      else                      hr_d = {hr1_q, hr0_q + 4'd1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_STOPPED;
      pre_q      <= '0;
      hr1_q      <= 4'd0;
      hr0_q      <= 4'd0;
      sec_tick_q <= 1'b0;
      daypass_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      {hr1_q, hr0_q} <= hr_d;
      sec_tick_q <= tick;
      daypass_q  <= c_m1 && hr_last;
      load_err_q <= set_time && !load_ok;
    end
  end

  assign disp_hr  = mode24 ? {hr1_q, hr0_q} : bin_to_bcd(hr_24_to_12(hr_bin));
  assign hr1      = disp_hr[7:4];
  assign hr0      = disp_hr[3:0];
  assign pm       = (hr_bin >= 7'd12);
  assign daypass  = daypass_q;
  assign sec_tick = sec_tick_q;
  assign load_err = load_err_q;

endmodule

// File: doc/watch_core.md
Name: watch_core

Overview:
- Parametrised single-clock timekeeper; successor to the ripple-clocked BCD watch.
- Chained BCD digit counters advance on an internal one-second tick enable. There are no derived clocks.
- Adds run-time 12h/24h display mode, validated time load, an AM/PM flag and a prescaler that holds the partial second when stopped.
- Feeds the display/alarm logic of the watch controller.

Parameters:
- CLK_PER_SEC, 1000, clk cycles per second tick (>=1; 1 = tick every running cycle).
- PRE_W, $clog2(CLK_PER_SEC+1), prescaler width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_resume  in  1  level sampled each clk; enter/stay RUNNING.
- stop  in  1  level sampled each clk; enter/stay STOPPED.
- set_time  in  1  load in_* digits this cycle.
- mode24  in  1  1 = 24h interpretation/display, 0 = 12h.
- in_hr1, in_hr0, in_min1, in_min0, in_sec1, in_sec0  in  4 each  BCD load digits.
- in_pm  in  1  PM flag for a 12h load; ignored when mode24=1.
- hr1, hr0, min1, min0, sec1, sec0  out  4 each  BCD time, hours formatted per mode24.
- pm  out  1  1 when internal hour >= 12 (valid in both modes).
- daypass  out  1  one-cycle pulse on wrap to 00:00:00.
- sec_tick  out  1  one-cycle pulse on each seconds advance.
- running  out  1  1 in RUNNING state.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Time is stored internally in 24h BCD form (00:00:00-23:59:59). Display hours are derived combinationally from stored state; no added latency.
- 12h display mapping: internal 00 -> 12, 01-12 -> unchanged, 13-23 -> minus 12.
- Reset (async): internal time 00:00:00, prescaler 0, state STOPPED, daypass/sec_tick/load_err 0, running 0, pm 0. Displayed hours after reset: 00 (24h) or 12 (12h).
- FSM has two states:
  - STOPPED -> RUNNING when start_resume=1 and stop=0.
  - RUNNING -> STOPPED when stop=1. Stop wins if both are asserted.
- Prescaler:
  - Counts only in RUNNING; wraps at CLK_PER_SEC-1, and that cycle is a tick.
  - Holds its value in STOPPED, so the partial second is preserved.
  - The tick is registered: time digits and sec_tick update on the clk edge ending the tick cycle.
- Carry chain: sec0 mod 10, sec1 mod 6, min0 mod 10, min1 mod 6, hours 00-23.
  - Hour BCD pair rolls 09 -> 10, 19 -> 20, 23 -> 00.
  - daypass=1 in the cycle the displayed time first reads 00:00:00 after a wrap from 23:59:59.
- Load (set_time=1):
  - Legal in either state; does not change state.
  - Clears the prescaler.
  - 24h validity: hour 00-23, min1<=5, sec1<=5, every digit <=9.
  - 12h validity: hour 01-12. Converted to internal form as 12AM -> 00, h PM -> h+12 (h != 12), 12PM -> 12.
  - Invalid input: time and prescaler unchanged, load_err pulses next cycle.
- Priority per cycle: reset > set_time > tick. A load and a tick in the same cycle produce the loaded value; no increment, no daypass.
- Changing mode24 changes only the displayed hours; stored time is unaffected.

Decomposition:
- Package watch_pkg holds:
  - State enum {ST_STOPPED, ST_RUNNING}.
  - Digit limit constants SEC1_MAX=5, MIN1_MAX=5, HR_MAX_24=23.
  - A 12h<->24h conversion function.
- One sub-module, bcd_mod_counter, parameter MOD:
  - Single BCD digit with enable, synchronous load, carry-out when at MOD-1 and enabled.
  - Instantiated for sec0, sec1, min0 and min1.
  - The hour pair is a dedicated 00-23 block.

Test Plan (CLK_PER_SEC=4):
- Reset asserted mid-run at 12:34:56 -> outputs 00:00:00, running=0, pm=0. Then set mode24=0 -> hours display 12.
- mode24=1: load 23:59:58, start_resume -> sec_tick at cycles 4 and 8. Displays 23:59:59, then 00:00:00 with daypass high for exactly that one cycle.
- mode24=0: load 11:59:59 with in_pm=1, run 4 cycles -> 12:00:00, pm=0, daypass pulse. A separate load of 11:59:59 with in_pm=0 -> 12:00:00 with pm=1 and no daypass.
- Invalid loads 24:00:00 (24h), 00:15:00 (12h) and 10:60:00 -> load_err pulse each; time unchanged.
- Run 2 cycles into a second, stop for 5 cycles, resume -> next sec_tick 2 cycles after resume. Asserting stop and start_resume together -> stays/goes STOPPED.
- set_time of 05:00:00 in the same cycle as a tick from 04:59:59 -> 05:00:00 with prescaler 0. Next tick arrives 4 cycles later.
